// File: rtl/arm_pipelined_pkg.sv
// Shared types and constants for the ARM pipelined Decode/Execute control stage.
package arm_pipelined_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic       pc_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       no_write;
        logic       branch;
        logic [1:0] alu_control;
        logic [1:0] flag_write;
        cond_e      cond;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/arm_pipelined_cond_check.sv
// Evaluates an ARM 4-bit condition field against the NZCV flags.
module arm_pipelined_cond_check
    import arm_pipelined_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond_e'(cond))
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = (n == v);
            LT: cond_ex = (n != v);
            GT: cond_ex = ~z & (n == v);
            LE: cond_ex = z | (n != v);
            AL: cond_ex = 1'b1;
            NV: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_pipelined_execute_control.sv
// Decode-to-Execute control register, NZCV flags register and condition gating.
module arm_pipelined_execute_control
    import arm_pipelined_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic       i_CLK,
    input  logic       i_NRESET,
    input  logic       i_Stall_Execute,
    input  logic       i_Flush_Execute,
    input  logic       i_PC_Source_Decode,
    input  logic       i_Reg_Write_Decode,
    input  logic       i_Mem_Write_Decode,
    input  logic       i_Mem_To_Reg_Decode,
    input  logic       i_ALU_Src_Decode,
    input  logic       i_No_Write_Decode,
    input  logic       i_Branch_Decode,
    input  logic [1:0] i_ALU_Control_Decode,
    input  logic [1:0] i_Flag_Write_Decode,
    input  logic [3:0] i_Cond_Decode,
    input  logic [3:0] i_ALU_Flags_Execute,
    output logic       o_PC_Source_Execute,
    output logic       o_Reg_Write_Execute,
    output logic       o_Mem_Write_Execute,
    output logic       o_Branch_Taken_Execute,
    output logic       o_Mem_To_Reg_Execute,
    output logic       o_ALU_Src_Execute,
    output logic [1:0] o_ALU_Control_Execute,
    output logic       o_Cond_Ex_Execute,
    output logic [3:0] o_Flags
);

    ctrl_t      d_ctrl;
    ctrl_t      r_ctrl;
    logic [3:0] r_flags;
    logic       cond_ex;

    always_comb begin
        d_ctrl             = CTRL_BUBBLE;
        d_ctrl.pc_src      = i_PC_Source_Decode;
        d_ctrl.reg_write   = i_Reg_Write_Decode;
        d_ctrl.mem_write   = i_Mem_Write_Decode;
        d_ctrl.mem_to_reg  = i_Mem_To_Reg_Decode;
        d_ctrl.alu_src     = i_ALU_Src_Decode;
        d_ctrl.no_write    = i_No_Write_Decode;
        d_ctrl.branch      = i_Branch_Decode;
        d_ctrl.alu_control = i_ALU_Control_Decode;
        d_ctrl.flag_write  = i_Flag_Write_Decode;
        d_ctrl.cond        = cond_e'(i_Cond_Decode);
    end

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            r_ctrl <= CTRL_BUBBLE;
        end else if (i_Flush_Execute) begin
            r_ctrl <= CTRL_BUBBLE;
        end else if (!i_Stall_Execute) begin
            r_ctrl <= d_ctrl;
        end
    end

    // Condition reads the registered flags only, so a flag-setting op affects the next instruction.
    arm_pipelined_cond_check u_cond_check (
        .cond    (r_ctrl.cond),
        .flags   (r_flags),
        .cond_ex (cond_ex)
    );

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            r_flags <= FLAGS_RESET;
        end else if (!i_Stall_Execute && cond_ex) begin
            if (r_ctrl.flag_write[1]) begin
                r_flags[FLAG_N] <= i_ALU_Flags_Execute[FLAG_N];
                r_flags[FLAG_Z] <= i_ALU_Flags_Execute[FLAG_Z];
            end
            if (r_ctrl.flag_write[0]) begin
                r_flags[FLAG_C] <= i_ALU_Flags_Execute[FLAG_C];
                r_flags[FLAG_V] <= i_ALU_Flags_Execute[FLAG_V];
            end
        end
    end

    assign o_PC_Source_Execute    = r_ctrl.pc_src & cond_ex;
    assign o_Reg_Write_Execute    = r_ctrl.reg_write & cond_ex & ~r_ctrl.no_write;
    assign o_Mem_Write_Execute    = r_ctrl.mem_write & cond_ex;
    assign o_Branch_Taken_Execute = r_ctrl.branch & cond_ex;
    assign o_Mem_To_Reg_Execute   = r_ctrl.mem_to_reg;
    assign o_ALU_Src_Execute      = r_ctrl.alu_src;
    assign o_ALU_Control_Execute  = r_ctrl.alu_control;
    assign o_Cond_Ex_Execute      = cond_ex;
    assign o_Flags                = r_flags;

endmodule

// File: tb/tb_arm_pipelined_execute_control.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural pipeline model.
module tb_arm_pipelined_execute_control;

    typedef struct packed {
        logic       pc, rw, mw, m2r, src, nw, br;
        logic [1:0] aluc, fw;
        logic [3:0] cond;
    } dec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] alu = '0;
    dec_t       d = '0;

    logic       o_pc, o_rw, o_mw, o_br, o_m2r, o_src, o_ce;
    logic [1:0] o_aluc;
    logic [3:0] o_flags;

    dec_t       m = '0;
    logic [3:0] m_flags = 4'b0100;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    arm_pipelined_execute_control #(.FLAGS_RESET(4'b0100)) dut (
        .i_CLK                  (clk),
        .i_NRESET               (rst_n),
        .i_Stall_Execute        (stall),
        .i_Flush_Execute        (flush),
        .i_PC_Source_Decode     (d.pc),
        .i_Reg_Write_Decode     (d.rw),
        .i_Mem_Write_Decode     (d.mw),
        .i_Mem_To_Reg_Decode    (d.m2r),
        .i_ALU_Src_Decode       (d.src),
        .i_No_Write_Decode      (d.nw),
        .i_Branch_Decode        (d.br),
        .i_ALU_Control_Decode   (d.aluc),
        .i_Flag_Write_Decode    (d.fw),
        .i_Cond_Decode          (d.cond),
        .i_ALU_Flags_Execute    (alu),
        .o_PC_Source_Execute    (o_pc),
        .o_Reg_Write_Execute    (o_rw),
        .o_Mem_Write_Execute    (o_mw),
        .o_Branch_Taken_Execute (o_br),
        .o_Mem_To_Reg_Execute   (o_m2r),
        .o_ALU_Src_Execute      (o_src),
        .o_ALU_Control_Execute  (o_aluc),
        .o_Cond_Ex_Execute      (o_ce),
        .o_Flags                (o_flags)
    );

    // ARM pseudocode form: even codes test a base predicate, odd codes invert it.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        if (c[0] && c[3:1] != 3'd7) return !base;
        return base;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic ce;
        ce = ref_cond(m.cond, m_flags);
        chk("cond_ex",   {3'b0, o_ce},  {3'b0, ce});
        chk("flags",     o_flags,       m_flags);
        chk("pc_src",    {3'b0, o_pc},  {3'b0, m.pc & ce});
        chk("reg_write", {3'b0, o_rw},  {3'b0, m.rw & ce & ~m.nw});
        chk("mem_write", {3'b0, o_mw},  {3'b0, m.mw & ce});
        chk("branch",    {3'b0, o_br},  {3'b0, m.br & ce});
        chk("mem_to_reg",{3'b0, o_m2r}, {3'b0, m.m2r});
        chk("alu_src",   {3'b0, o_src}, {3'b0, m.src});
        chk("alu_ctrl",  {2'b0, o_aluc},{2'b0, m.aluc});
    endtask

    // One clock edge of the model, then compare outputs shortly after the edge.
    task automatic step();
        logic       ce;
        logic [3:0] nf;
        dec_t       nm;
        ce = ref_cond(m.cond, m_flags);
        nf = m_flags;
        if (!stall && ce) begin
            if (m.fw[1]) nf[3:2] = alu[3:2];
            if (m.fw[0]) nf[1:0] = alu[1:0];
        end
        nm = flush ? dec_t'(0) : (stall ? m : d);
        @(posedge clk);
        #1;
        if (rst_n) begin
            m = nm;
            m_flags = nf;
        end
        check_all();
    endtask

    task automatic set_dec(input logic [6:0] bits, input logic [1:0] fw, input logic [3:0] cond);
        {d.pc, d.rw, d.mw, d.m2r, d.src, d.nw, d.br} = bits;
        d.aluc = 2'b00;
        d.fw   = fw;
        d.cond = cond;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        m = '0;
        m_flags = 4'b0100;
        check_all();
        chk("reset_flags", o_flags, 4'b0100);
    endtask

    // Drive a flag-setting AL op through Execute so flags become f; leaves a NOP in Decode.
    task automatic force_flags(input logic [3:0] f);
        set_dec(7'b0, 2'b11, 4'b1110);
        step();
        set_dec(7'b0, 2'b00, 4'b1110);
        alu = f;
        step();
    endtask

    initial begin
        // reset asserted mid-cycle, held across an edge, released mid-cycle
        #12;
        do_reset();
        step();
        rst_n = 1'b1;
        set_dec(7'b0100000, 2'b00, 4'b0000);
        step();
        chk("eq_regwrite_after_reset", {3'b0, o_rw}, 4'b0001);

        // SUBS then BNE: SUBS sets Z, so BNE must not branch
        set_dec(7'b0100000, 2'b11, 4'b1110);
        step();
        set_dec(7'b1000001, 2'b00, 4'b0001);
        alu = 4'b0110;
        step();
        chk("subs_flags", o_flags, 4'b0110);
        chk("bne_branch", {3'b0, o_br}, 4'b0000);
        chk("bne_pcsrc",  {3'b0, o_pc}, 4'b0000);

        // ADDGE / CMPGE with flags 1000 (fail) and 1001 (pass)
        force_flags(4'b1000);
        set_dec(7'b0100000, 2'b00, 4'b1010);
        step();
        set_dec(7'b0100010, 2'b11, 4'b1010);
        step();
        set_dec(7'b0, 2'b00, 4'b1110);
        alu = 4'b0110;
        step();
        chk("cmpge_fail_flags", o_flags, 4'b1000);
        force_flags(4'b1001);
        set_dec(7'b0100000, 2'b00, 4'b1010);
        step();
        chk("addge_regwrite", {3'b0, o_rw}, 4'b0001);
        set_dec(7'b0100010, 2'b11, 4'b1010);
        step();
        chk("cmpge_regwrite", {3'b0, o_rw}, 4'b0000);
        set_dec(7'b0, 2'b00, 4'b1110);
        alu = 4'b0100;
        step();
        chk("cmpge_flags", o_flags, 4'b0100);

        // independent flag halves
        force_flags(4'b0000);
        set_dec(7'b0, 2'b10, 4'b1110);
        step();
        set_dec(7'b0, 2'b00, 4'b1110);
        alu = 4'b1111;
        step();
        chk("fw10_flags", o_flags, 4'b1100);
        force_flags(4'b0000);
        set_dec(7'b0, 2'b01, 4'b1110);
        step();
        set_dec(7'b0, 2'b00, 4'b1110);
        alu = 4'b1111;
        step();
        chk("fw01_flags", o_flags, 4'b0011);

        // stall three cycles with a flag-setting op in Execute
        set_dec(7'b1111111, 2'b11, 4'b1110);
        step();
        stall = 1'b1;
        set_dec(7'b0, 2'b00, 4'b0000);
        alu = 4'b1010;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk("stall_flags_hold", o_flags, 4'b0011);
        end
        flush = 1'b1;
        step();
        chk("stall_flush_regwrite", {3'b0, o_rw}, 4'b0000);
        chk("stall_flush_memwrite", {3'b0, o_mw}, 4'b0000);
        chk("stall_flush_flags", o_flags, 4'b0011);
        stall = 1'b0;
        flush = 1'b0;

        // full condition sweep
        for (int unsigned f = 0; f < 16; f++) begin
            force_flags(4'(f));
            for (int unsigned c = 0; c < 16; c++) begin
                set_dec(7'b1110001, 2'b00, 4'(c));
                step();
                chk("cond_sweep", {3'b0, o_ce}, {3'b0, ref_cond(4'(c), 4'(f))});
            end
        end

        // random traffic with an occasional mid-run reset
        for (int unsigned i = 0; i < 400; i++) begin
            d     = dec_t'($urandom);
            alu   = 4'($urandom);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            if (i == 200) begin
                do_reset();
                rst_n = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
